ext_output_history_display: RTL

Parametrised successor to the team's AR history display. Keeps a DEPTH-entry shift history of DATA_W-bit words pushed from the datapath. Multiplexes the history onto two 7-segment banks with a one-hot slot select and a programmable scan prescaler. Adds freeze, synchronous clear, blanking of unfilled entries, occupancy count and a dropped-push counter.

---
 rtl/ext_display_pkg.sv | 26 ++
 rtl/seg7_word_encoder.sv | 32 +++
 rtl/ext_output_history_display.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ext_display_pkg.sv
// ext_display_pkg
// Shared constants and helpers for the output history display.
//   HEX_SEG    : hex digit to segment byte table (bit7..bit1 = a..g, bit0 = dp)
//   SEG_BLANK  : all-off segment byte
//   DP_BIT     : position of the decimal point inside a segment byte
//   hex_to_seg : encode one nibble plus decimal point into a segment byte
package ext_display_pkg;

    localparam int DP_BIT = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Index 0 is the least significant byte, so the list runs F down to 0.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h9E, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
        logic [7:0] seg;
        seg         = HEX_SEG[nibble];
        seg[DP_BIT] = dp;
        return seg;
    endfunction

endpackage

// File: rtl/seg7_word_encoder.sv
// seg7_word_encoder
// Combinational encoder of one DATA_W-bit word into DATA_W/4 segment bytes.
// Ports:
//   word     in  DATA_W        word to display
//   blank    in  1             force every byte (dp included) to all-off
//   segments out (DATA_W/4)*8  segment bytes, most significant digit in the top byte;
//                              dp is lit only on the least significant digit
module seg7_word_encoder
    import ext_display_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]         word,
    input  logic                      blank,
    output logic [(DATA_W/4)*8-1:0]   segments
);

    localparam int DIGITS = DATA_W / 4;

    // Per-digit encoding; digit 0 carries the decimal point.
    always_comb begin
        segments = {((DATA_W/4)*8){1'b0}};
        for (int d = 0; d < DIGITS; d++) begin
            if (blank) begin
                segments[d*8 +: 8] = SEG_BLANK;
            end else begin
                segments[d*8 +: 8] = hex_to_seg(word[d*4 +: 4], (d == 0));
            end
        end
    end

endmodule

// File: rtl/ext_output_history_display.sv
// ext_output_history_display
// DEPTH-entry shift history of pushed words, scanned onto two 7-segment banks.
// Ports:
//   clock, reset       clock; synchronous active-high reset
//   push_en, out_en    a push happens only when both are 1
//   data_in            word to record (hist[0] is newest)
//   freeze             refuse pushes and count them in dropped
//   clear              clear history, count and dropped (scan keeps running)
//   blank_empty        show entries with index >= count as all-off
//   seg_a / seg_b      bank 0 shows hist[slot], bank 1 shows hist[slot+SLOTS]
//   select             one-hot slot select, MSB = slot 0
//   count              valid entries, saturating at DEPTH
//   dropped            refused pushes, saturating at 255
module ext_output_history_display
    import ext_display_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int SCAN_DIV = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_en,
    input  logic                         out_en,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         freeze,
    input  logic                         clear,
    input  logic                         blank_empty,
    output logic [(DATA_W/4)*8-1:0]      seg_a,
    output logic [(DATA_W/4)*8-1:0]      seg_b,
    output logic [DEPTH/2-1:0]           select,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   dropped
);

    localparam int SLOTS  = DEPTH / 2;
    localparam int SEG_W  = (DATA_W / 4) * 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] hist_r [DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic [7:0]        dropped_r;
    logic [DIV_W-1:0]  div_r;
    logic [SLOT_W-1:0] slot_r;
    logic [SEG_W-1:0]  seg_a_r;
    logic [SEG_W-1:0]  seg_b_r;
    logic [SLOTS-1:0]  select_r;

    logic              push_s;
    logic [IDX_W-1:0]  idx_a_s;
    logic [IDX_W-1:0]  idx_b_s;
    logic [DATA_W-1:0] word_a_s;
    logic [DATA_W-1:0] word_b_s;
    logic              blank_a_s;
    logic              blank_b_s;
    logic [SEG_W-1:0]  enc_a_s;
    logic [SEG_W-1:0]  enc_b_s;
    logic [SLOTS-1:0]  select_s;

    assign push_s = push_en & out_en;

    // Scan prescaler and slot counter; only reset restarts the scan.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r  <= {DIV_W{1'b0}};
            slot_r <= {SLOT_W{1'b0}};
        end else if (div_r == DIV_LAST) begin
            div_r  <= {DIV_W{1'b0}};
            slot_r <= (slot_r == SLOT_LAST) ? {SLOT_W{1'b0}} : slot_r + SLOT_W'(1);
        end else begin
            div_r  <= div_r + DIV_W'(1);
        end
    end

    // History, occupancy and dropped counter; clear wins over freeze, freeze over push.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_r[i] <= {DATA_W{1'b0}};
            end
            count_r   <= {CNT_W{1'b0}};
            dropped_r <= 8'h00;
        end else if (push_s && freeze) begin
            if (dropped_r != 8'hFF) begin
                dropped_r <= dropped_r + 8'h01;
            end
        end else if (push_s) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                hist_r[i] <= hist_r[i-1];
            end
            hist_r[0] <= data_in;
            if (count_r != CNT_FULL) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    // Select the two words for the current slot and decide blanking against the pre-update count.
    always_comb begin
        idx_a_s   = IDX_W'(slot_r);
        idx_b_s   = IDX_W'(slot_r) + IDX_W'(SLOTS);
        word_a_s  = hist_r[idx_a_s];
        word_b_s  = hist_r[idx_b_s];
        blank_a_s = blank_empty & (CNT_W'(idx_a_s) >= count_r);
        blank_b_s = blank_empty & (CNT_W'(idx_b_s) >= count_r);
        select_s  = {SLOTS{1'b0}};
        for (int s = 0; s < SLOTS; s++) begin
            select_s[SLOTS-1-s] = (slot_r == SLOT_W'(s));
        end
    end

    seg7_word_encoder #(.DATA_W(DATA_W)) u_enc_a (
        .word     (word_a_s),
        .blank    (blank_a_s),
        .segments (enc_a_s)
    );

    seg7_word_encoder #(.DATA_W(DATA_W)) u_enc_b (
        .word     (word_b_s),
        .blank    (blank_b_s),
        .segments (enc_b_s)
    );

    // Output registers; select stays all-zero until the first post-reset cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_a_r  <= {SEG_W{1'b0}};
            seg_b_r  <= {SEG_W{1'b0}};
            select_r <= {SLOTS{1'b0}};
        end else begin
            seg_a_r  <= enc_a_s;
            seg_b_r  <= enc_b_s;
            select_r <= select_s;
        end
    end

    assign seg_a   = seg_a_r;
    assign seg_b   = seg_b_r;
    assign select  = select_r;
    assign count   = count_r;
    assign dropped = dropped_r;

endmodule
